// File: rtl/seq_unshifter.sv
// seq_unshifter
//   Multi-cycle shifter that moves a LEN-bit word toward the higher bit index.
//   Bit 0 is the leftmost bit. The word moves by at most MAX_SHIFT_MAG
//   positions per clock until the requested amount is used up. With wa=0 the
//   vacated low-index bits fill with zero. With wa=1 the word rotates.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   in_valid   Ip/shamt valid
//   in_ready   block can accept a word (only in IDLE)
//   Ip         word to shift, [0:LEN-1]
//   shamt      total shift amount, unsigned, SW bits
//   out_valid  Op holds the finished result (DONE state)
//   out_ready  consumer accepts Op
//   Op         result, driven straight from the data register
module seq_unshifter #(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter bit wa            = 1'b0,
  parameter int SW            = $clog2(LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [0:LEN-1] Ip,
  input  logic [SW-1:0]  shamt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [0:LEN-1] Op
);

  localparam logic [SW-1:0] LEN_W = SW'(LEN);
  localparam logic [SW-1:0] MAX_W = SW'(MAX_SHIFT_MAG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [0:LEN-1] data;
  logic [SW-1:0]  rem;

  logic [SW-1:0]  norm;
  logic [SW-1:0]  step;
  logic [0:LEN-1] shifted;

  assign Op = data;

  // Largest step allowed this cycle; never exceeds rem, so rem cannot wrap.
  always_comb begin
    step = rem;
    if (rem > MAX_W) begin
      step = MAX_W;
    end
  end

  // Moving toward the higher index is a right shift of the vector as written
  // (index 0 is the MSB position of the value).
  generate
    if (wa) begin : g_rotate
      // A full-turn rotate is the identity, so the amount reduces modulo LEN.
      always_comb begin
        norm = shamt % LEN_W;
      end
      // step is never 0 in SHIFT, so the left shift amount stays below LEN.
      always_comb begin
        shifted = (data >> step) | (data << (LEN_W - step));
      end
    end else begin : g_zero_fill
      // Anything at or past LEN clears the word; clamp so the shift count
      // stays bounded.
      always_comb begin
        norm = shamt;
        if (shamt > LEN_W) begin
          norm = LEN_W;
        end
      end
      always_comb begin
        shifted = data >> step;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data      <= '0;
      rem       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= Ip;
            rem      <= norm;
            in_ready <= 1'b0;
            if (norm == '0) begin
              // Nothing to shift: present the word on the next cycle.
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data <= shifted;
          rem  <= rem - step;
          if (rem == step) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_unshifter.sv
// Bench for seq_unshifter: a zero-fill instance (wa=0) and a rotate instance
// (wa=1) share every input, so each vector checks both fill modes at once.
module tb_seq_unshifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [0:7] ip;
  logic [3:0] shamt;

  logic       in_ready0, out_valid0, in_ready1, out_valid1;
  logic [0:7] op0, op1;

  always #5 clk = ~clk;

  seq_unshifter #(.LEN(8), .MAX_SHIFT_MAG(2), .wa(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .Ip(ip), .shamt(shamt), .out_valid(out_valid0), .out_ready(out_ready),
    .Op(op0)
  );

  seq_unshifter #(.LEN(8), .MAX_SHIFT_MAG(2), .wa(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .Ip(ip), .shamt(shamt), .out_valid(out_valid1), .out_ready(out_ready),
    .Op(op1)
  );

  typedef struct {
    logic [7:0] ip;
    logic [3:0] s;
    logic [7:0] exp0;  // zero-fill result
    logic [7:0] exp1;  // rotate result
    int         lat0;  // edges after accept until out_valid (zero-fill)
    int         lat1;  // same for rotate
  } vec_t;

  vec_t vecs[9];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Present a word for exactly one edge; inputs change #1 after the edge.
  task automatic launch(input logic [7:0] w, input logic [3:0] s);
    ip       = w;
    shamt    = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until each instance raises out_valid.
  task automatic wait_done(output int l0, output int l1);
    l0 = -1;
    l1 = -1;
    for (int k = 0; k <= 12; k++) begin
      if (out_valid0 && l0 < 0) l0 = k;
      if (out_valid1 && l1 < 0) l1 = k;
      if (l0 >= 0 && l1 >= 0) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int l0, l1;
    launch(v.ip, v.s);
    wait_done(l0, l1);
    check({tag, " lat wa0"}, l0, v.lat0);
    check({tag, " lat wa1"}, l1, v.lat1);
    check({tag, " op wa0"}, op0, v.exp0);
    check({tag, " op wa1"}, op1, v.exp1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " ready after"}, {in_ready0, in_ready1, out_valid0, out_valid1}, 4'b1100);
    $display("vec %s ip=%b s=%0d op0=%b op1=%b lat=%0d/%0d", tag, v.ip, v.s, op0, op1, l0, l1);
  endtask

  initial begin
    int   l0, l1;
    vec_t v;

    vecs[0] = '{8'b1000_0000, 4'd3,  8'b0001_0000, 8'b0001_0000, 2, 2};
    vecs[1] = '{8'b1010_0101, 4'd0,  8'b1010_0101, 8'b1010_0101, 0, 0};
    vecs[2] = '{8'b0000_0011, 4'd3,  8'b0000_0000, 8'b0110_0000, 2, 2};
    vecs[3] = '{8'b0000_0011, 4'd12, 8'b0000_0000, 8'b0011_0000, 4, 2};
    vecs[4] = '{8'b1011_0001, 4'd8,  8'b0000_0000, 8'b1011_0001, 4, 0};
    vecs[5] = '{8'b1101_0010, 4'd1,  8'b0110_1001, 8'b0110_1001, 1, 1};
    vecs[6] = '{8'b1101_0011, 4'd5,  8'b0000_0110, 8'b1001_1110, 3, 3};
    vecs[7] = '{8'b1111_1111, 4'd15, 8'b0000_0000, 8'b1111_1111, 4, 4};
    vecs[8] = '{8'b0111_0110, 4'd9,  8'b0000_0000, 8'b0011_1011, 4, 1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ip        = 8'h00;
    shamt     = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset flags", {in_ready0, in_ready1, out_valid0, out_valid1}, 4'b1100);
    check("reset op", {op0, op1}, 16'h0000);

    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("t%0d", i), vecs[i]);
    end

    // Backpressure: hold the result, new words must be refused.
    launch(8'b1000_0000, 4'd3);
    wait_done(l0, l1);
    check("bp lat", {l0[7:0], l1[7:0]}, {8'd2, 8'd2});
    for (int c = 0; c < 5; c++) begin
      ip       = 8'b1111_1111;
      shamt    = 4'd0;
      in_valid = (c % 2) == 0;
      @(posedge clk);
      #1;
      check($sformatf("bp hold flags c%0d", c), {in_ready0, in_ready1, out_valid0, out_valid1}, 4'b0011);
      check($sformatf("bp hold op c%0d", c), {op0, op1}, {8'b0001_0000, 8'b0001_0000});
      $display("bp cycle %0d in_valid=%b op0=%b op1=%b", c, in_valid, op0, op1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp release flags", {in_ready0, in_ready1, out_valid0, out_valid1}, 4'b1100);
    check("bp release op", {op0, op1}, {8'b0001_0000, 8'b0001_0000});
    @(posedge clk);
    #1;
    check("bp idle stays", {in_ready0, in_ready1, out_valid0, out_valid1}, 4'b1100);
    $display("bp released in_ready=%b/%b", in_ready0, in_ready1);

    // Reset during the second SHIFT cycle discards the partial result.
    launch(8'b1111_1111, 4'd7);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst flags", {in_ready0, in_ready1, out_valid0, out_valid1}, 4'b1100);
    check("midrst op", {op0, op1}, 16'h0000);
    $display("mid-shift reset op0=%b op1=%b", op0, op1);
    v = '{8'b1100_0000, 4'd1, 8'b0110_0000, 8'b0110_0000, 1, 1};
    run_vec("post_rst", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
